mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port `memory` block between up to NUM_REQ requesters, e.g. instruction-side PTW, data-side PTW and debug reader.
- Accepts one request at a time, issues it on the memory valid/ready request channel, collects the response and routes it back to the granted requester.
- Sits between the page-table walkers and `memory`. At most one transaction is outstanding.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT_RESP (only used with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester request accept, one-hot or zero.
- req_addr_i  input  NUM_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- resp_valid_o  output  NUM_REQ  per-requester response valid, one-hot or zero.
- resp_ready_i  input  NUM_REQ  per-requester response ready.
- resp_data_o  output  DATA_W  response data, shared by all requesters.
- resp_err_o  output  1  timeout error flag, qualified by resp_valid_o.
- mem_req_valid_o  output  1  request valid to memory.
- mem_req_ready_i  input  1  memory request ready.
- mem_addr_o  output  ADDR_W  address to memory.
- mem_resp_valid_i  input  1  memory response valid.
- mem_resp_ready_o  output  1  response ready to memory.
- mem_data_i  input  DATA_W  memory read data.

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), grant index, address and data registers = 0. All outputs 0. Reset mid-transaction abandons it; there is no replay after reset.
- States: IDLE, ISSUE, WAIT_RESP, RESPOND.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, searching from last_grant+1 modulo NUM_REQ.
  - req_ready_o = one-hot(winner), combinational from req_valid_i, only in IDLE.
  - On an edge with any valid: latch winner index and its address, go to ISSUE.
  - No valid: stay in IDLE, req_ready_o=0.
- ISSUE:
  - mem_req_valid_o=1; mem_addr_o=latched address, held stable.
  - On an edge with mem_req_ready_i=1: go to WAIT_RESP.
  - Otherwise hold valid and address; never deassert valid before the handshake.
- WAIT_RESP:
  - mem_resp_ready_o=1.
  - On an edge with mem_resp_valid_i=1: latch mem_data_i, clear err, go to RESPOND.
- RESPOND:
  - resp_valid_o[grant]=1; resp_data_o=latched data, stable until the handshake.
  - On an edge with resp_ready_i[grant]=1: last_grant=grant, go to IDLE.
  - resp_ready_i of non-granted ports is ignored.
- Outputs outside their state are 0: mem_req_valid_o, mem_resp_ready_o, resp_valid_o, req_ready_o. mem_addr_o and resp_data_o hold their last registered value.
- Latency: minimum 4 cycles from request accept to resp_valid_o (accept, ISSUE, WAIT_RESP, RESPOND), plus memory stall cycles.
- Requests arriving outside IDLE wait; requesters must hold valid and address until accepted.
- Simultaneous requests are resolved by round-robin rotation. A requester that keeps valid high re-competes next IDLE cycle and loses to any other pending requester.
- Address is passed through unmodified. No alignment or range checking; out-of-range handling belongs to `memory`.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT_RESP, incremented each WAIT_RESP cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no mem_resp_valid_i: go to RESPOND with data=0 and resp_err_o=1.
  - A late memory response arriving after the timeout is not accepted; mem_resp_ready_o=0 outside WAIT_RESP.
- Undefined: no counter; WAIT_RESP waits indefinitely; resp_err_o tied 0.

Test Plan:
- Reset: rst low mid-ISSUE -> all outputs 0 immediately; after release, state IDLE, req_ready_o=0 with no valids.
- Single read: req 0 reads 0x400 -> mem_addr_o=0x400; resp_valid_o=2'b01, resp_data_o=0x00000801; 0x804 -> 0x1100000F.
- Contention: req 0 at 0x800 and req 1 at 0x404 asserted together from reset -> req 0 served first (0x1000000F), then req 1 (0x12340007); repeat with both held -> grants alternate 1,0,1.
- Backpressure: hold resp_ready_i[0]=0 for 10 cycles on 0x808 -> resp_valid_o[0] and 0x12000007 held stable; mem_req_valid_o stays 0; no new grant.
- Out of range: req 1 reads 0x1000 -> resp_data_o=0x00000000, resp_err_o=0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory model never responding -> resp_valid_o asserted after 8 WAIT_RESP cycles with data=0, resp_err_o=1; next request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: round-robin arbiter giving NUM_REQ requesters one-at-a-time access to a single-port memory.
// Define ARB_TIMEOUT_EN to add a WAIT_RESP watchdog that answers with resp_err_o after TIMEOUT_CYCLES.
module mem_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic                      resp_err_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic                      mem_resp_valid_i,
    output logic                      mem_resp_ready_o,
    input  logic [DATA_W-1:0]         mem_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        RESPOND
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  winner;
    logic              any_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Search starts just after the last served requester, so a requester that
    // keeps valid high loses to any other pending requester.
    always_comb begin
        winner    = last_grant_q;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_valid && req_valid_i[(int'(last_grant_q) + i) % NUM_REQ]) begin
                any_valid = 1'b1;
                winner    = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
            end
        end
    end

    // NOTE: every next-state value and output gets a default first, so no path
    // through the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_d          = grant_q;
        addr_d           = addr_q;
        data_d           = data_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d            = cnt_q;
        err_d            = err_q;
`endif
        req_ready_o      = '0;
        resp_valid_o     = '0;
        mem_req_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_o[winner] = 1'b1;
                    grant_d             = winner;
                    addr_d              = req_addr_i[int'(winner)*ADDR_W +: ADDR_W];
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = WAIT_RESP;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_RESP: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    data_d  = mem_data_i;
                    state_d = RESPOND;
`ifdef ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESPOND: begin
                resp_valid_o[grant_q] = 1'b1;
                if (resp_ready_i[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign mem_addr_o  = addr_q;
    assign resp_data_o = data_q;

`ifdef ARB_TIMEOUT_EN
    assign resp_err_o = err_q && (state_q == RESPOND);
`else
    assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: directed vectors plus hand sequences for reset, contention,
// backpressure and (with ARB_TIMEOUT_EN) the watchdog, against a small memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_addr_i;
    logic [1:0]  resp_valid_o;
    logic [1:0]  resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_data_i;

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls
    int cyc         = 0;
    int stall_until = 0;
    bit mem_silent  = 1'b0;

    mem_arbiter #(
        .NUM_REQ       (2),
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_data_o     (resp_data_o),
        .resp_err_o      (resp_err_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_ready_o(mem_resp_ready_o),
        .mem_data_i      (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h400: return 32'h0000_0801;
            32'h404: return 32'h1234_0007;
            32'h800: return 32'h1000_000F;
            32'h804: return 32'h1100_000F;
            32'h808: return 32'h1200_0007;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory model: acts on falling edges; answers one cycle after a request handshake.
    initial begin
        bit          req_fire;
        bit          resp_fire;
        bit          pend;
        logic [31:0] fire_addr;
        logic [31:0] pend_addr;
        req_fire         = 1'b0;
        resp_fire        = 1'b0;
        pend             = 1'b0;
        fire_addr        = '0;
        pend_addr        = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (resp_fire) mem_resp_valid_i = 1'b0;
            if (req_fire && !mem_silent) begin
                pend      = 1'b1;
                pend_addr = fire_addr;
            end
            mem_req_ready_i = (cyc >= stall_until);
            if (pend && !mem_resp_valid_i) begin
                mem_resp_valid_i = 1'b1;
                mem_data_i       = mem_lookup(pend_addr);
                pend             = 1'b0;
            end
            req_fire  = mem_req_valid_o && mem_req_ready_i;
            fire_addr = mem_addr_o;
            resp_fire = mem_resp_valid_i && mem_resp_ready_o;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no event within cycle budget", name);
    endtask

    // One full transaction; called at a falling edge +1 with the DUT in IDLE.
    task automatic do_txn(input string name, input logic [1:0] mask, input bit keep,
                          input int g, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int         n;
        logic [1:0] oh;
        oh          = 2'b01 << g;
        req_valid_i = mask;
        #1;
        n = 0;
        while (req_ready_o == 2'b00 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready_o == 2'b00) begin
            bound_fail({name, "_accept"});
            return;
        end
        check({name, "_req_ready"}, 64'(req_ready_o), 64'(oh));
        @(negedge clk);
        if (!keep) req_valid_i[g] = 1'b0;
        #1;
        check({name, "_mem_valid"}, 64'(mem_req_valid_o), 64'd1);
        check({name, "_mem_addr"}, 64'(mem_addr_o), 64'(exp_addr));
        n = 0;
        while (resp_valid_o == 2'b00 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (resp_valid_o == 2'b00) begin
            bound_fail({name, "_resp"});
            return;
        end
        check({name, "_resp_valid"}, 64'(resp_valid_o), 64'(oh));
        check({name, "_resp_data"}, 64'(resp_data_o), 64'(exp_data));
        check({name, "_resp_err"}, 64'(resp_err_o), 64'(exp_err));
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        resp_ready_i = oh;
        @(negedge clk);
        resp_ready_i = 2'b00;
        #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mask;
        logic [31:0] a0;
        logic [31:0] a1;
        int          grant;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"contend_r0", 2'b11, 32'h800, 32'h404,  0, 32'h800,  32'h1000_000F};
        vecs[1] = '{"contend_r1", 2'b10, 32'h800, 32'h404,  1, 32'h404,  32'h1234_0007};
        vecs[2] = '{"read_400",   2'b01, 32'h400, 32'h404,  0, 32'h400,  32'h0000_0801};
        vecs[3] = '{"oob_1000",   2'b10, 32'h400, 32'h1000, 1, 32'h1000, 32'h0000_0000};
        vecs[4] = '{"read_804",   2'b01, 32'h804, 32'h1000, 0, 32'h804,  32'h1100_000F};

        rst          = 1'b0;
        req_valid_i  = 2'b00;
        req_addr_i   = '0;
        resp_ready_i = 2'b00;

        // Reset state, then reset in the middle of ISSUE
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_resp_data", 64'(resp_data_o), 64'd0);
        check("rst_resp_err", 64'(resp_err_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_no_valid_ready", 64'(req_ready_o), 64'd0);
        stall_until = cyc + 1000;
        req_addr_i  = {32'h0, 32'h400};
        req_valid_i = 2'b01;
        @(negedge clk);
        req_valid_i = 2'b00;
        #1;
        check("issue_mem_valid", 64'(mem_req_valid_o), 64'd1);
        check("issue_mem_addr", 64'(mem_addr_o), 64'h400);
        rst = 1'b0;
        #1;
        check("midrst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("midrst_req_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        stall_until = 0;
        @(negedge clk);
        #1;
        check("postrst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("postrst_req_ready", 64'(req_ready_o), 64'd0);

        // Directed vectors: contention from reset, single reads, out of range
        for (int i = 0; i < 5; i++) begin
            req_addr_i = {vecs[i].a1, vecs[i].a0};
            do_txn(vecs[i].name, vecs[i].mask, 1'b0, vecs[i].grant,
                   vecs[i].exp_addr, vecs[i].exp_data, 1'b0, 2);
        end

        // Both requesters held: grants alternate 1,0,1 (last served was 0)
        req_addr_i = {32'h404, 32'h400};
        do_txn("alt_a", 2'b11, 1'b1, 1, 32'h404, 32'h1234_0007, 1'b0, 2);
        do_txn("alt_b", 2'b11, 1'b1, 0, 32'h400, 32'h0000_0801, 1'b0, 2);
        do_txn("alt_c", 2'b11, 1'b1, 1, 32'h404, 32'h1234_0007, 1'b0, 2);
        req_valid_i = 2'b00;

        // Memory stall in ISSUE, then response backpressure with the other requester waiting
        req_addr_i  = {32'h404, 32'h808};
        stall_until = cyc + 4;
        req_valid_i = 2'b11;
        #1;
        check("bp_grant", 64'(req_ready_o), 64'b01);
        @(negedge clk);
        req_valid_i[0] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_mem_valid", 64'(mem_req_valid_o), 64'd1);
            check("stall_mem_addr", 64'(mem_addr_o), 64'h808);
            @(negedge clk); #1;
        end
        begin
            int n;
            n = 0;
            while (resp_valid_o == 2'b00 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            if (resp_valid_o == 2'b00) bound_fail("bp_resp");
        end
        resp_ready_i = 2'b10;
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", 64'(resp_valid_o), 64'b01);
            check("bp_resp_data", 64'(resp_data_o), 64'h1200_0007);
            check("bp_mem_valid", 64'(mem_req_valid_o), 64'd0);
            check("bp_no_grant", 64'(req_ready_o), 64'd0);
            @(negedge clk); #1;
        end
        resp_ready_i = 2'b01;
        @(negedge clk);
        resp_ready_i = 2'b00;
        #1;
        check("bp_released", 64'(resp_valid_o), 64'd0);
        do_txn("bp_waiter", 2'b10, 1'b0, 1, 32'h404, 32'h1234_0007, 1'b0, 2);

`ifdef ARB_TIMEOUT_EN
        // Silent memory: error response after 8 WAIT_RESP cycles, then a normal read
        mem_silent = 1'b1;
        req_addr_i = {32'h404, 32'h400};
        do_txn("timeout", 2'b01, 1'b0, 0, 32'h400, 32'h0, 1'b1, 9);
        mem_silent = 1'b0;
        req_addr_i = {32'h404, 32'h804};
        do_txn("after_timeout", 2'b01, 1'b0, 0, 32'h804, 32'h1100_000F, 1'b0, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
